// File: rtl/rv32.sv
// Core-wide constants for the rv32 integer datapath.
package rv32;
    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
endpackage

// File: rtl/rv_regfile.sv
// Integer register file: NUM_READ registered read ports, one write port, x0 hardwired to zero,
// optional write-to-read bypass and a post-reset clear sweep gating the ready output.
module rv_regfile #(
    parameter int XLEN           = rv32::XLEN,
    parameter int REG_ADDR_WIDTH = rv32::REG_ADDR_WIDTH,
    parameter int NUM_READ       = 2,
    parameter int BYPASS         = 1,
    parameter int ZERO_ON_RESET  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic                               ready,
    input  logic [NUM_READ-1:0]                rd_en,
    input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*XLEN-1:0]           rd_data,
    input  logic                               we,
    input  logic [REG_ADDR_WIDTH-1:0]          wr_addr,
    input  logic [XLEN-1:0]                    wr_data
);
    localparam int RAW       = REG_ADDR_WIDTH;
    localparam int REG_COUNT = 2 ** RAW;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_INIT,
        ST_READY
    } state_t;

    localparam state_t         RST_STATE = (ZERO_ON_RESET != 0) ? ST_CLEAR : ST_INIT;
    localparam logic [RAW-1:0] PTR_FIRST = RAW'(1);
    localparam logic [RAW-1:0] PTR_LAST  = '1;

    state_t         r_state;
    state_t         w_state_next;
    logic [RAW-1:0] r_ptr;
    logic [RAW-1:0] w_ptr_next;

    // Entry 0 is never written or read; x0 is produced as a constant on the read side.
    logic [XLEN-1:0] r_mem [REG_COUNT];

    logic            w_wr_fire;
    logic            w_mem_we;
    logic [RAW-1:0]  w_mem_addr;
    logic [XLEN-1:0] w_mem_data;

    assign ready     = (r_state == ST_READY);
    assign w_wr_fire = ready && we && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_STATE;
            r_ptr   <= PTR_FIRST;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == PTR_LAST) begin
                    w_state_next = ST_READY;
                end
            end
            ST_INIT:  w_state_next = ST_READY;
            ST_READY: w_state_next = ST_READY;
            default:  w_state_next = RST_STATE;
        endcase
    end

    // The sweep and the user write share the single array write port; they are mutually exclusive.
    always_comb begin
        w_mem_we   = !rst && ((r_state == ST_CLEAR) || w_wr_fire);
        w_mem_addr = (r_state == ST_CLEAR) ? r_ptr : wr_addr;
        w_mem_data = (r_state == ST_CLEAR) ? '0 : wr_data;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [RAW-1:0]  w_addr;
            logic [XLEN-1:0] r_data;

            assign w_addr = rd_addr[gi*RAW +: RAW];

            always_ff @(posedge clk) begin
                if (rst || !ready) begin
                    r_data <= '0;
                end else if (rd_en[gi]) begin
                    if (w_addr == '0) begin
                        r_data <= '0;
                    end else if ((BYPASS != 0) && w_wr_fire && (wr_addr == w_addr)) begin
                        r_data <= wr_data;
                    end else begin
                        r_data <= r_mem[w_addr];
                    end
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = r_data;
        end
    endgenerate

endmodule
